hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline hazard and sequencing controller for the five-stage RISC-V core. Drives stall and flush controls into the fetch/decode, decode/execute, execute/memory and memory/writeback pipeline registers, and operand-forwarding selects into the execute stage. It resolves three hazard classes:
- load-use data hazards;
- taken branches and jumps;
- multi-cycle data-memory waits, via a small FSM with a timeout.

It also keeps saturating stall and flush performance counters.

## Interface
- TIMEOUT, 16, max consecutive memory-wait cycles before error; 0 disables the timeout
- CNT_W, 16, width of performance counters
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- rs1_d, rs2_d  in  5 each  source registers in decode
- rs1_ex, rs2_ex, rd_ex  in  5 each  source and destination registers in execute
- result_src_ex  in  2  value 2'b01 marks a load in execute
- pc_src_ex  in  1  taken branch or jump resolved in execute
- rd_mem, register_write_mem  in  5, 1  memory-stage destination and write enable
- rd_wb, register_write_wb  in  5, 1  writeback-stage destination and write enable
- mem_req_mem  in  1  memory stage is issuing a data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- forward_a_ex, forward_b_ex  out  2 each  operand select: 00 register file, 01 writeback result, 10 memory ALU result
- stall_fetch, stall_decode, stall_execute, stall_memory  out  1 each  hold the corresponding pipeline register
- flush_decode, flush_execute, flush_writeback  out  1 each  load a bubble (all zeros) into the corresponding pipeline register
- mem_timeout  out  1  sticky error flag
- stall_cycles, flush_events  out  CNT_W each  performance counters

## Operation
- FSM states: RUN, MEM_WAIT, ERROR. Reset state is RUN.
- Forwarding is combinational in every state. Evaluated per operand; shown for A, B is identical using rs2_ex:
  - 10 if register_write_mem, rd_mem != 0 and rd_mem == rs1_ex;
  - else 01 if register_write_wb, rd_wb != 0 and rd_wb == rs1_ex;
  - else 00.
- lw_stall = (result_src_ex == 2'b01) && rd_ex != 0 && (rd_ex == rs1_d || rd_ex == rs2_d).
- mem_hold = state is MEM_WAIT or ERROR, or (state is RUN and mem_req_mem && !mem_ready).
- When mem_hold is set:
  - stall_fetch, stall_decode, stall_execute, stall_memory = 1;
  - flush_writeback = 1;
  - flush_decode = flush_execute = 0. The branch or load stays frozen in execute and is handled on release.
- When mem_hold is clear:
  - stall_execute = stall_memory = flush_writeback = 0;
  - flush_decode = pc_src_ex;
  - flush_execute = pc_src_ex | lw_stall;
  - stall_fetch = stall_decode = lw_stall & ~pc_src_ex. A redirect overrides a load-use stall.
- RUN:
  - if mem_req_mem && !mem_ready: go to MEM_WAIT and set wait_cnt to 1;
  - else stay in RUN.
- MEM_WAIT:
  - if mem_ready: this cycle is still held; go to RUN and clear wait_cnt;
  - else if TIMEOUT != 0 and wait_cnt == TIMEOUT - 1: go to ERROR and set mem_timeout;
  - else increment wait_cnt.
- ERROR: all stalls held, mem_timeout = 1. Exits only by reset.
- The wait_cnt width is clog2(TIMEOUT+1), minimum 1.
- stall_cycles increments on every cycle with stall_fetch = 1.
- flush_events increments on every cycle with flush_decode = 1.
- Both counters saturate at 2^CNT_W - 1; they never wrap.

## Timing
- FSM, wait_cnt, mem_timeout and counters update on the rising edge of clk.
- Control outputs are combinational (Mealy) from inputs and state. They settle before the falling-edge capture of the pipeline registers.
- Counter outputs reflect an event one rising edge after that event.
- While rst_n = 0, registered state takes its reset values at the rising edge:
  - state RUN, wait_cnt 0, mem_timeout 0, counters 0.
- While rst_n = 0, outputs are forced combinationally:
  - forward selects 00;
  - all stalls 0;
  - flush_decode = flush_execute = flush_writeback = 1, so the pipeline fills with bubbles;
  - counters do not count.
- Reset asserted in MEM_WAIT or ERROR returns to RUN at the next rising edge, overriding mem_ready.
- A memory wait that ends with mem_ready in RUN's first cycle costs zero stall cycles.
- A wait of N cycles without ready costs N+1 held cycles, the last one being the ready cycle.
- Simultaneous pc_src_ex and mem_hold: the flush is deferred until the first cycle with mem_hold clear.

## Test plan
- Load-use hazard:
  - stimulus: result_src_ex=01, rd_ex=5, rs2_d=5, no memory request;
  - required: stall_fetch=stall_decode=flush_execute=1, flush_decode=0; stall_cycles goes 0 -> 1 next edge.
- Load to x0:
  - stimulus: rd_ex=0, rs1_d=0;
  - required: no stall, no flush.
- Forwarding:
  - stimulus: rd_mem=rd_wb=7, both write enables set, rs1_ex=7;
  - required: forward_a_ex=10, forward_b_ex=00 with rs2_ex=3;
  - then drop register_write_mem: required forward_a_ex=01.
- Redirect overrides stall:
  - stimulus: pc_src_ex=1 together with a load-use match;
  - required: flush_decode=flush_execute=1, stall_fetch=0; flush_events +1.
- Memory wait with deferred flush:
  - stimulus: mem_req_mem=1, mem_ready low for 3 cycles then high, pc_src_ex=1 throughout;
  - required: all stalls and flush_writeback high for 4 cycles, flush_decode 0 during them, then 1 in cycle 5; FSM back in RUN.
- Timeout:
  - stimulus: TIMEOUT=4, mem_ready never asserted;
  - required: mem_timeout=1 after the 4th held cycle, stalls stay high indefinitely;
  - then rst_n=0 for one edge: required mem_timeout=0, counters 0, state RUN.

Source files
------------

// File: rtl/hazard_controller_if.sv
// Signal bundle between the five-stage pipeline and its hazard controller.
// The slave side is the controller and the master side is the pipeline (or a bench).
interface hazard_controller_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       rs1_d;
   logic [4:0]       rs2_d;
   logic [4:0]       rs1_ex;
   logic [4:0]       rs2_ex;
   logic [4:0]       rd_ex;
   logic [1:0]       result_src_ex;
   logic             pc_src_ex;
   logic [4:0]       rd_mem;
   logic             register_write_mem;
   logic [4:0]       rd_wb;
   logic             register_write_wb;
   logic             mem_req_mem;
   logic             mem_ready;
   logic [1:0]       forward_a_ex;
   logic [1:0]       forward_b_ex;
   logic             stall_fetch;
   logic             stall_decode;
   logic             stall_execute;
   logic             stall_memory;
   logic             flush_decode;
   logic             flush_execute;
   logic             flush_writeback;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_events;

   modport master (
      output rs1_d, rs2_d, rs1_ex, rs2_ex, rd_ex, result_src_ex, pc_src_ex,
             rd_mem, register_write_mem, rd_wb, register_write_wb,
             mem_req_mem, mem_ready,
      input  forward_a_ex, forward_b_ex,
             stall_fetch, stall_decode, stall_execute, stall_memory,
             flush_decode, flush_execute, flush_writeback,
             mem_timeout, stall_cycles, flush_events
   );

   modport slave (
      input  rs1_d, rs2_d, rs1_ex, rs2_ex, rd_ex, result_src_ex, pc_src_ex,
             rd_mem, register_write_mem, rd_wb, register_write_wb,
             mem_req_mem, mem_ready,
      output forward_a_ex, forward_b_ex,
             stall_fetch, stall_decode, stall_execute, stall_memory,
             flush_decode, flush_execute, flush_writeback,
             mem_timeout, stall_cycles, flush_events
   );
endinterface

// File: rtl/hazard_controller.sv
// Hazard controller for the five-stage core. It handles forwarding, load-use stalls,
// redirect flushes and data-memory waits with a timeout, and it keeps saturating stall/flush counters.
module hazard_controller #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input logic                clk,
   input logic                rst_n,
   hazard_controller_if.slave bus
);

   localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0]  flush_events_q, flush_events_d;

   logic              lw_stall;
   logic              mem_hold;
   logic [1:0]        fwd_a, fwd_b;
   logic              stall_fetch_c, stall_decode_c, stall_execute_c, stall_memory_c;
   logic              flush_decode_c, flush_execute_c, flush_writeback_c;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic       wr_mem,
                                          input logic [4:0] rd_m,
                                          input logic       wr_wb,
                                          input logic [4:0] rd_w);
      if (wr_mem && rd_m != 5'd0 && rd_m == rs) return 2'b10;
      if (wr_wb && rd_w != 5'd0 && rd_w == rs) return 2'b01;
      return 2'b00;
   endfunction

   assign lw_stall = (bus.result_src_ex == 2'b01) && (bus.rd_ex != 5'd0) &&
                     ((bus.rd_ex == bus.rs1_d) || (bus.rd_ex == bus.rs2_d));
   assign mem_hold = (state_q != RUN) || (bus.mem_req_mem && !bus.mem_ready);

   always_comb begin
      // NOTE: every variable gets a default first, so no branch can infer a latch.
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      unique case (state_q)
         RUN: begin
            if (bus.mem_req_mem && !bus.mem_ready) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (bus.mem_ready) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (TIMEOUT != 0 && wait_cnt_q == WAIT_LAST) begin
               state_d       = ERROR;
               mem_timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         ERROR:   state_d = ERROR;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      fwd_a             = 2'b00;
      fwd_b             = 2'b00;
      stall_fetch_c     = 1'b0;
      stall_decode_c    = 1'b0;
      stall_execute_c   = 1'b0;
      stall_memory_c    = 1'b0;
      flush_decode_c    = 1'b0;
      flush_execute_c   = 1'b0;
      flush_writeback_c = 1'b0;
      if (!rst_n) begin
         // Bubbles fill the pipeline while the core is held in reset.
         flush_decode_c    = 1'b1;
         flush_execute_c   = 1'b1;
         flush_writeback_c = 1'b1;
      end else begin
         fwd_a = fwd_sel(bus.rs1_ex, bus.register_write_mem, bus.rd_mem,
                         bus.register_write_wb, bus.rd_wb);
         fwd_b = fwd_sel(bus.rs2_ex, bus.register_write_mem, bus.rd_mem,
                         bus.register_write_wb, bus.rd_wb);
         if (mem_hold) begin
            stall_fetch_c     = 1'b1;
            stall_decode_c    = 1'b1;
            stall_execute_c   = 1'b1;
            stall_memory_c    = 1'b1;
            flush_writeback_c = 1'b1;
         end else begin
            flush_decode_c  = bus.pc_src_ex;
            flush_execute_c = bus.pc_src_ex | lw_stall;
            stall_fetch_c   = lw_stall & ~bus.pc_src_ex;
            stall_decode_c  = lw_stall & ~bus.pc_src_ex;
         end
      end
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_events_d = flush_events_q;
      if (stall_fetch_c && stall_cycles_q != {CNT_W{1'b1}})
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      if (flush_decode_c && flush_events_q != {CNT_W{1'b1}})
         flush_events_d = flush_events_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values.
      if (!rst_n) begin
         state_q        <= RUN;
         wait_cnt_q     <= '0;
         mem_timeout_q  <= 1'b0;
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         state_q        <= state_d;
         wait_cnt_q     <= wait_cnt_d;
         mem_timeout_q  <= mem_timeout_d;
         stall_cycles_q <= stall_cycles_d;
         flush_events_q <= flush_events_d;
      end
   end

   assign bus.forward_a_ex    = fwd_a;
   assign bus.forward_b_ex    = fwd_b;
   assign bus.stall_fetch     = stall_fetch_c;
   assign bus.stall_decode    = stall_decode_c;
   assign bus.stall_execute   = stall_execute_c;
   assign bus.stall_memory    = stall_memory_c;
   assign bus.flush_decode    = flush_decode_c;
   assign bus.flush_execute   = flush_execute_c;
   assign bus.flush_writeback = flush_writeback_c;
   assign bus.mem_timeout     = mem_timeout_q;
   assign bus.stall_cycles    = stall_cycles_q;
   assign bus.flush_events    = flush_events_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller. Expected outputs are queued when each step is driven,
// then popped and compared after the combinational outputs settle.
module tb_hazard_controller;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   hazard_controller_if #(.CNT_W(16)) bus1 ();
   hazard_controller_if #(.CNT_W(3))  bus2 ();

   hazard_controller #(.TIMEOUT(4), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   // Narrow counters and no timeout: exercises saturation and the disabled-timeout path.
   hazard_controller #(.TIMEOUT(0), .CNT_W(3)) dut_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   typedef struct packed {
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic [3:0]  stall;  // fetch, decode, execute, memory
      logic [2:0]  flush;  // decode, execute, writeback
      logic        tmo;
      logic [15:0] sc;
      logic [15:0] fe;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic push(input logic [1:0] fa, input logic [1:0] fb, input logic [3:0] stall,
                       input logic [2:0] flush, input logic tmo, input int sc, input int fe);
      obs_t e;
      e.fa = fa; e.fb = fb; e.stall = stall; e.flush = flush; e.tmo = tmo;
      e.sc = 16'(sc); e.fe = 16'(fe);
      exp_q.push_back(e);
   endtask

   function automatic obs_t sample1();
      obs_t o;
      o.fa    = bus1.forward_a_ex;
      o.fb    = bus1.forward_b_ex;
      o.stall = {bus1.stall_fetch, bus1.stall_decode, bus1.stall_execute, bus1.stall_memory};
      o.flush = {bus1.flush_decode, bus1.flush_execute, bus1.flush_writeback};
      o.tmo   = bus1.mem_timeout;
      o.sc    = bus1.stall_cycles;
      o.fe    = bus1.flush_events;
      return o;
   endfunction

   function automatic obs_t sample2();
      obs_t o;
      o.fa    = bus2.forward_a_ex;
      o.fb    = bus2.forward_b_ex;
      o.stall = {bus2.stall_fetch, bus2.stall_decode, bus2.stall_execute, bus2.stall_memory};
      o.flush = {bus2.flush_decode, bus2.flush_execute, bus2.flush_writeback};
      o.tmo   = bus2.mem_timeout;
      o.sc    = {13'd0, bus2.stall_cycles};
      o.fe    = {13'd0, bus2.flush_events};
      return o;
   endfunction

   task automatic compare(input string tag, input obs_t o);
      obs_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: no expected entry queued", tag);
      end else begin
         e = exp_q.pop_front();
         checks++;
         assert ({o.fa, o.fb} === {e.fa, e.fb}) else begin
            errors++;
            $error("FAIL %s fwd: got a=%b b=%b expected a=%b b=%b", tag, o.fa, o.fb, e.fa, e.fb);
         end
         checks++;
         assert (o.stall === e.stall) else begin
            errors++;
            $error("FAIL %s stall(f,d,e,m): got %b expected %b", tag, o.stall, e.stall);
         end
         checks++;
         assert (o.flush === e.flush) else begin
            errors++;
            $error("FAIL %s flush(d,e,wb): got %b expected %b", tag, o.flush, e.flush);
         end
         checks++;
         assert (o.tmo === e.tmo) else begin
            errors++;
            $error("FAIL %s mem_timeout: got %b expected %b", tag, o.tmo, e.tmo);
         end
         checks++;
         assert ({o.sc, o.fe} === {e.sc, e.fe}) else begin
            errors++;
            $error("FAIL %s counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   tag, o.sc, o.fe, e.sc, e.fe);
         end
      end
   endtask

   task automatic idle1();
      bus1.rs1_d = 5'd0; bus1.rs2_d = 5'd0; bus1.rs1_ex = 5'd0; bus1.rs2_ex = 5'd0;
      bus1.rd_ex = 5'd0; bus1.result_src_ex = 2'b00; bus1.pc_src_ex = 1'b0;
      bus1.rd_mem = 5'd0; bus1.register_write_mem = 1'b0;
      bus1.rd_wb = 5'd0; bus1.register_write_wb = 1'b0;
      bus1.mem_req_mem = 1'b0; bus1.mem_ready = 1'b0;
   endtask

   task automatic idle2();
      bus2.rs1_d = 5'd0; bus2.rs2_d = 5'd0; bus2.rs1_ex = 5'd0; bus2.rs2_ex = 5'd0;
      bus2.rd_ex = 5'd0; bus2.result_src_ex = 2'b00; bus2.pc_src_ex = 1'b0;
      bus2.rd_mem = 5'd0; bus2.register_write_mem = 1'b0;
      bus2.rd_wb = 5'd0; bus2.register_write_wb = 1'b0;
      bus2.mem_req_mem = 1'b0; bus2.mem_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle1();
      idle2();

      // Reset: outputs forced even with a forwarding match and a redirect + load-use present.
      @(negedge clk);
      bus1.rd_mem = 5'd7; bus1.register_write_mem = 1'b1; bus1.rs1_ex = 5'd7;
      bus1.pc_src_ex = 1'b1; bus1.result_src_ex = 2'b01; bus1.rd_ex = 5'd5; bus1.rs1_d = 5'd5;
      push(2'b00, 2'b00, 4'b0000, 3'b111, 1'b0, 0, 0);
      #1 compare("reset_force", sample1());

      @(negedge clk);
      rst_n = 1'b1;
      idle1();
      push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 0, 0);
      #1 compare("idle", sample1());

      @(negedge clk);
      bus1.result_src_ex = 2'b01; bus1.rd_ex = 5'd5; bus1.rs2_d = 5'd5;
      push(2'b00, 2'b00, 4'b1100, 3'b010, 1'b0, 0, 0);
      #1 compare("load_use", sample1());

      @(negedge clk);
      bus1.rd_ex = 5'd0; bus1.rs1_d = 5'd0; bus1.rs2_d = 5'd0;
      push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1, 0);
      #1 compare("load_x0", sample1());

      @(negedge clk);
      bus1.result_src_ex = 2'b00;
      bus1.rd_mem = 5'd7; bus1.rd_wb = 5'd7; bus1.register_write_mem = 1'b1;
      bus1.register_write_wb = 1'b1; bus1.rs1_ex = 5'd7; bus1.rs2_ex = 5'd3;
      push(2'b10, 2'b00, 4'b0000, 3'b000, 1'b0, 1, 0);
      #1 compare("fwd_mem", sample1());

      @(negedge clk);
      bus1.register_write_mem = 1'b0;
      push(2'b01, 2'b00, 4'b0000, 3'b000, 1'b0, 1, 0);
      #1 compare("fwd_wb", sample1());

      @(negedge clk);
      bus1.register_write_mem = 1'b1; bus1.rd_mem = 5'd0; bus1.rs1_ex = 5'd0; bus1.rs2_ex = 5'd7;
      push(2'b00, 2'b01, 4'b0000, 3'b000, 1'b0, 1, 0);
      #1 compare("fwd_x0", sample1());

      @(negedge clk);
      idle1();
      bus1.pc_src_ex = 1'b1; bus1.result_src_ex = 2'b01; bus1.rd_ex = 5'd5; bus1.rs1_d = 5'd5;
      push(2'b00, 2'b00, 4'b0000, 3'b110, 1'b0, 1, 0);
      #1 compare("redirect", sample1());

      // Memory wait with a pending redirect: 3 cycles without ready, then the ready cycle.
      @(negedge clk);
      idle1();
      bus1.pc_src_ex = 1'b1; bus1.mem_req_mem = 1'b1;
      push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 1, 1);
      #1 compare("wait_1", sample1());
      @(negedge clk);
      push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 2, 1);
      #1 compare("wait_2", sample1());
      @(negedge clk);
      push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 3, 1);
      #1 compare("wait_3", sample1());
      @(negedge clk);
      bus1.mem_ready = 1'b1;
      push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 4, 1);
      #1 compare("wait_ready", sample1());
      @(negedge clk);
      bus1.mem_req_mem = 1'b0; bus1.mem_ready = 1'b0;
      push(2'b00, 2'b00, 4'b0000, 3'b110, 1'b0, 5, 1);
      #1 compare("deferred_flush", sample1());

      @(negedge clk);
      bus1.pc_src_ex = 1'b0; bus1.mem_req_mem = 1'b1; bus1.mem_ready = 1'b1;
      push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 5, 2);
      #1 compare("ready_first", sample1());

      // Timeout after the 4th held cycle, then ERROR ignores ready and redirects.
      @(negedge clk);
      bus1.mem_ready = 1'b0;
      push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 5, 2);
      #1 compare("tmo_1", sample1());
      @(negedge clk);
      push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 6, 2);
      #1 compare("tmo_2", sample1());
      @(negedge clk);
      push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 7, 2);
      #1 compare("tmo_3", sample1());
      @(negedge clk);
      push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 8, 2);
      #1 compare("tmo_4", sample1());
      @(negedge clk);
      bus1.mem_req_mem = 1'b0; bus1.mem_ready = 1'b1;
      push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b1, 9, 2);
      #1 compare("error_ready", sample1());
      @(negedge clk);
      bus1.pc_src_ex = 1'b1;
      push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b1, 10, 2);
      #1 compare("error_redirect", sample1());

      @(negedge clk);
      rst_n = 1'b0;
      push(2'b00, 2'b00, 4'b0000, 3'b111, 1'b1, 11, 2);
      #1 compare("error_reset", sample1());

      // Back in RUN: a request completing immediately must not hold.
      @(negedge clk);
      rst_n = 1'b1;
      idle1();
      bus1.mem_req_mem = 1'b1; bus1.mem_ready = 1'b1;
      push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 0, 0);
      #1 compare("after_reset", sample1());

      // Saturation instance: 3-bit stall counter stops at 7, no timeout ever fires.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus2.mem_req_mem = 1'b1; bus2.mem_ready = 1'b0;
         push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, (i < 7) ? i : 7, 0);
         #1 compare($sformatf("sat_%0d", i), sample2());
      end
      @(negedge clk);
      bus2.mem_ready = 1'b1;
      push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 7, 0);
      #1 compare("sat_ready", sample2());
      @(negedge clk);
      idle2();
      push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 7, 0);
      #1 compare("sat_release", sample2());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
